// File: rtl/rbe_streamer_sched.sv
// Transfer scheduler for the RBE streamer: one store and three round-robin load requesters
// share the single TCDM path. Optional watchdog: define RBE_STREAMER_SCHED_WATCHDOG_EN.
module rbe_streamer_sched #(
    parameter int unsigned WATCHDOG_CYCLES = 4096
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic [2:0] ld_req_i,
    input  logic       st_req_i,
    output logic [2:0] ld_done_o,
    output logic       st_done_o,
    input  logic       src_ready_i,
    input  logic       snk_ready_i,
    input  logic       src_done_i,
    input  logic       snk_done_i,
    input  logic       fifo_empty_i,
    output logic       src_start_o,
    output logic       snk_start_o,
    output logic [1:0] ld_which_sel_o,
    output logic       ld_st_sel_o,
    output logic       busy_o,
    output logic       err_o
);

    typedef enum logic [2:0] {IDLE, DRAIN, ISSUE, BUSY, DONE} state_e;

    state_e     state_q, state_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic       own_st_q, own_st_d;
    logic [1:0] own_ld_q, own_ld_d;
    logic [1:0] which_sel_q, which_sel_d;
    logic       st_sel_q, st_sel_d;

    logic [1:0] rr_pick;
    logic       ld_any, tgt_ready, tgt_done, start_fire, done_fire;

`ifdef RBE_STREAMER_SCHED_WATCHDOG_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic        err_q, err_d;
`endif

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // First pending load at or after the pointer, wrapping norm -> feat.
    always_comb begin
        logic [1:0] i0, i1, i2;
        i0     = rr_ptr_q;
        i1     = rr_next(i0);
        i2     = rr_next(i1);
        ld_any = |ld_req_i;
        if (ld_req_i[i0])      rr_pick = i0;
        else if (ld_req_i[i1]) rr_pick = i1;
        else                   rr_pick = i2;
    end

    assign tgt_ready  = own_st_q ? snk_ready_i : src_ready_i;
    assign tgt_done   = own_st_q ? snk_done_i  : src_done_i;
    assign start_fire = (state_q == ISSUE) && enable_i && !clear_i && tgt_ready;
    assign done_fire  = (state_q == DONE)  && enable_i && !clear_i;

    assign src_start_o    = start_fire && !own_st_q;
    assign snk_start_o    = start_fire &&  own_st_q;
    assign ld_done_o      = (done_fire && !own_st_q) ? (3'b001 << own_ld_q) : 3'b000;
    assign st_done_o      = done_fire && own_st_q;
    assign ld_which_sel_o = which_sel_q;
    assign ld_st_sel_o    = st_sel_q;
    assign busy_o         = (state_q != IDLE);

    always_comb begin
        // NOTE: every next-state signal starts from its held value so no path infers a latch.
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        own_st_d    = own_st_q;
        own_ld_d    = own_ld_q;
        which_sel_d = which_sel_q;
        st_sel_d    = st_sel_q;
`ifdef RBE_STREAMER_SCHED_WATCHDOG_EN
        wd_cnt_d    = wd_cnt_q;
        err_d       = err_q;
`endif
        if (enable_i) begin
            case (state_q)
                IDLE: begin
                    if (st_req_i || ld_any) begin
                        own_st_d = st_req_i;
                        own_ld_d = st_req_i ? own_ld_q : rr_pick;
                        if (st_req_i != st_sel_q) begin
                            state_d = DRAIN;
                        end else begin
                            state_d = ISSUE;
                            if (!st_req_i) which_sel_d = rr_pick;
                        end
                    end
                end
                // Selects must not move until the FIFO holds nothing of the old direction.
                DRAIN: begin
                    if (fifo_empty_i) begin
                        st_sel_d = own_st_q;
                        if (!own_st_q) which_sel_d = own_ld_q;
                        state_d = ISSUE;
                    end
                end
                ISSUE: if (start_fire) state_d = BUSY;
                BUSY:  if (tgt_done) state_d = DONE;
                DONE: begin
                    if (!own_st_q) rr_ptr_d = rr_next(own_ld_q);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
`ifdef RBE_STREAMER_SCHED_WATCHDOG_EN
            if (state_q == ISSUE || state_q == BUSY) begin
                wd_cnt_d = wd_cnt_q + 32'd1;
                if (wd_cnt_d == WATCHDOG_CYCLES) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end else if (state_d == ISSUE) begin
                wd_cnt_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 2'd0;
            own_st_q    <= 1'b0;
            own_ld_q    <= 2'd0;
            which_sel_q <= 2'd0;
            st_sel_q    <= 1'b0;
`ifdef RBE_STREAMER_SCHED_WATCHDOG_EN
            wd_cnt_q    <= '0;
            err_q       <= 1'b0;
`endif
        end else if (clear_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 2'd0;
            own_st_q    <= 1'b0;
            own_ld_q    <= 2'd0;
            which_sel_q <= 2'd0;
            st_sel_q    <= 1'b0;
`ifdef RBE_STREAMER_SCHED_WATCHDOG_EN
            wd_cnt_q    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            own_st_q    <= own_st_d;
            own_ld_q    <= own_ld_d;
            which_sel_q <= which_sel_d;
            st_sel_q    <= st_sel_d;
`ifdef RBE_STREAMER_SCHED_WATCHDOG_EN
            wd_cnt_q    <= wd_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

`ifdef RBE_STREAMER_SCHED_WATCHDOG_EN
    assign err_o = err_q;
`else
    // Without the watchdog the timeout parameter has no effect and the error never rises.
    assign err_o = (WATCHDOG_CYCLES == 32'd0) && 1'b0;
`endif

endmodule

// File: tb/tb_rbe_streamer_sched.sv
// Randomized and directed bench for rbe_streamer_sched against a transaction-level model
// of the arbitration, drain, issue and completion rules.
module tb_rbe_streamer_sched;

    localparam int WD = 16;

    logic       clk = 1'b0;
    logic       rst_n, clear, enable, st_req, src_ready, snk_ready, src_done, snk_done, fifo_empty;
    logic [2:0] ld_req;
    logic [2:0] ld_done_o;
    logic       st_done_o, src_start_o, snk_start_o, ld_st_sel_o, busy_o, err_o;
    logic [1:0] ld_which_sel_o;

    always #5 clk = ~clk;

    rbe_streamer_sched #(.WATCHDOG_CYCLES(WD)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
        .ld_req_i(ld_req), .st_req_i(st_req), .ld_done_o(ld_done_o), .st_done_o(st_done_o),
        .src_ready_i(src_ready), .snk_ready_i(snk_ready), .src_done_i(src_done),
        .snk_done_i(snk_done), .fifo_empty_i(fifo_empty), .src_start_o(src_start_o),
        .snk_start_o(snk_start_o), .ld_which_sel_o(ld_which_sel_o), .ld_st_sel_o(ld_st_sel_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Transaction-level reference: where the current transfer is and what the selects show.
    typedef enum {M_IDLE, M_START, M_BUSY, M_DONE} mphase_e;
    mphase_e ph;
    int  m_ptr, m_ld, m_which, m_wd;
    bit  m_st, m_sel_st, m_drain, m_err;

    int  src_tmr, snk_tmr, done_lat, t0;
    bit  rand_mode;
    logic [2:0] seen_ld_done;
    logic       seen_st_done;
    int  start_log[$];
    int  start_cyc[$];
    int  ld_done_cyc, err_rise_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = M_IDLE; m_ptr = 0; m_ld = 0; m_which = 0; m_wd = 0;
        m_st = 0; m_sel_st = 0; m_drain = 0; m_err = 0;
    endtask

    task automatic wd_tick();
`ifdef RBE_STREAMER_SCHED_WATCHDOG_EN
        m_wd++;
        if (m_wd == WD) begin
            m_err = 1;
            ph    = M_DONE;
        end
`endif
    endtask

    task automatic model_check();
        logic [10:0] got, exp;
        logic [2:0]  e_ld;
        bit          e_src, e_snk, e_st, tgt_rdy, tgt_dn, found;
        cyc++;
        got = {busy_o, src_start_o, snk_start_o, ld_done_o, st_done_o, ld_st_sel_o, ld_which_sel_o, err_o};
        seen_ld_done = ld_done_o;
        seen_st_done = st_done_o;
        if (src_start_o || snk_start_o) begin
            start_log.push_back(snk_start_o ? 4 + int'(ld_which_sel_o) : int'(ld_which_sel_o));
            start_cyc.push_back(cyc);
        end
        if (|ld_done_o) ld_done_cyc = cyc;
        if (err_o === 1'b1 && err_rise_cyc < 0) err_rise_cyc = cyc;
        if (src_start_o && done_lat > 0) src_tmr = rand_mode ? int'($urandom_range(5, 1)) : done_lat;
        if (snk_start_o && done_lat > 0) snk_tmr = rand_mode ? int'($urandom_range(5, 1)) : done_lat;

        if (!rst_n) begin
            check("reset_outputs", 32'(got), 32'd0);
            model_reset();
            return;
        end
        if (clear) begin
            check("clear_pulses", 32'(got[9:4]), 32'd0);
            model_reset();
            return;
        end

        tgt_rdy = m_st ? snk_ready : src_ready;
        tgt_dn  = m_st ? snk_done : src_done;
        e_src = 0; e_snk = 0; e_st = 0; e_ld = 3'b000;
        if (enable) begin
            if (ph == M_START && !m_drain && tgt_rdy) begin
                e_src = !m_st;
                e_snk = m_st;
            end
            if (ph == M_DONE) begin
                if (m_st) e_st = 1;
                else      e_ld = 3'b001 << m_ld;
            end
        end
        exp = {ph != M_IDLE, e_src, e_snk, e_ld, e_st, m_sel_st, 2'(m_which), m_err};
        check("cycle_outputs", 32'(got), 32'(exp));

        if (!enable) return;
        case (ph)
            M_IDLE: begin
                if (st_req || |ld_req) begin
                    m_st  = st_req;
                    found = 0;
                    if (!m_st) begin
                        for (int k = 0; k < 3; k++) begin
                            if (!found && ld_req[(m_ptr + k) % 3]) begin
                                m_ld  = (m_ptr + k) % 3;
                                found = 1;
                            end
                        end
                    end
                    m_drain = (m_st != m_sel_st);
                    if (!m_drain) begin
                        if (!m_st) m_which = m_ld;
                        m_wd = 0;
                    end
                    ph = M_START;
                end
            end
            M_START: begin
                if (m_drain) begin
                    if (fifo_empty) begin
                        m_drain  = 0;
                        m_sel_st = m_st;
                        if (!m_st) m_which = m_ld;
                        m_wd = 0;
                    end
                end else begin
                    if (tgt_rdy) ph = M_BUSY;
                    wd_tick();
                end
            end
            M_BUSY: begin
                if (tgt_dn) ph = M_DONE;
                wd_tick();
            end
            M_DONE: begin
                if (!m_st) m_ptr = (m_ld + 1) % 3;
                ph = M_IDLE;
            end
            default: ph = M_IDLE;
        endcase
    endtask

    task automatic randomize_inputs();
        for (int b = 0; b < 3; b++) begin
            if (!ld_req[b]) begin
                if ($urandom_range(3, 0) == 0) ld_req[b] = 1'b1;
            end else if (!(ph != M_IDLE && !m_st && m_ld == b) && $urandom_range(15, 0) == 0) begin
                ld_req[b] = 1'b0;
            end
        end
        if (!st_req) begin
            if ($urandom_range(5, 0) == 0) st_req = 1'b1;
        end else if (!(ph != M_IDLE && m_st) && $urandom_range(15, 0) == 0) begin
            st_req = 1'b0;
        end
        src_ready  = ($urandom_range(3, 0) != 0);
        snk_ready  = ($urandom_range(3, 0) != 0);
        fifo_empty = 1'($urandom_range(1, 0));
        clear      = ($urandom_range(299, 0) == 0);
        if (ph == M_BUSY && $urandom_range(7, 0) == 0) begin
            if (m_st) src_done = 1'b1;
            else      snk_done = 1'b1;
        end
        if (ph == M_START && $urandom_range(7, 0) == 0) begin
            src_done = 1'b1;
            snk_done = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        if (rand_mode) enable = ($urandom_range(15, 0) != 0);
        src_done = 1'b0;
        snk_done = 1'b0;
        if (enable) begin
            if (src_tmr > 0) begin src_tmr--; if (src_tmr == 0) src_done = 1'b1; end
            if (snk_tmr > 0) begin snk_tmr--; if (snk_tmr == 0) snk_done = 1'b1; end
        end
        ld_req = ld_req & ~seen_ld_done;
        if (seen_st_done) st_req = 1'b0;
        if (rand_mode) randomize_inputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; clear = 1'b0; enable = 1'b1; ld_req = 3'b000; st_req = 1'b0;
        src_ready = 1'b1; snk_ready = 1'b1; fifo_empty = 1'b1;
        src_tmr = 0; snk_tmr = 0; src_done = 1'b0; snk_done = 1'b0;
        step();
        rst_n = 1'b1;
        start_log.delete();
        start_cyc.delete();
        ld_done_cyc  = -1;
        err_rise_cyc = -1;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; enable = 1'b1; ld_req = 3'b000; st_req = 1'b0;
        src_ready = 1'b1; snk_ready = 1'b1; src_done = 1'b0; snk_done = 1'b0; fifo_empty = 1'b1;
        done_lat = 3; rand_mode = 0; src_tmr = 0; snk_tmr = 0;
        seen_ld_done = 3'b000; seen_st_done = 1'b0; ld_done_cyc = -1; err_rise_cyc = -1;
        model_reset();
        step();

        // Single feat load, done five cycles after the start.
        apply_reset();
        done_lat = 5; t0 = cyc + 1; ld_req = 3'b001;
        repeat (10) step();
        check("feat_n_starts", start_log.size(), 1);
        if (start_log.size() > 0) begin
            check("feat_start_cycle", start_cyc[0] - t0, 1);
            check("feat_start_sel", start_log[0], 0);
        end
        check("feat_done_cycle", ld_done_cyc - t0, 7);

        // Round-robin with all loads held.
        apply_reset();
        done_lat = 2;
        repeat (40) begin ld_req = 3'b111; step(); end
        ld_req = 3'b000;
        repeat (4) step();
        check("rr_n_starts", start_log.size() >= 4, 1);
        if (start_log.size() >= 4) begin
            check("rr_grant0", start_log[0], 0);
            check("rr_grant1", start_log[1], 1);
            check("rr_grant2", start_log[2], 2);
            check("rr_grant3", start_log[3], 0);
        end

        // Store beats a pending weight load; FIFO stays full for the first drain cycles.
        apply_reset();
        done_lat = 3; t0 = cyc + 1; st_req = 1'b1; ld_req = 3'b010; fifo_empty = 1'b0;
        repeat (4) step();
        fifo_empty = 1'b1;
        repeat (16) step();
        check("drain_n_starts", start_log.size(), 2);
        if (start_log.size() == 2) begin
            check("drain_store_first", start_log[0], 4);
            check("drain_store_cycle", start_cyc[0] - t0, 5);
            check("drain_weight_next", start_log[1], 1);
        end

        // Source not ready for four ISSUE cycles.
        apply_reset();
        done_lat = 2; t0 = cyc + 1; ld_req = 3'b001; src_ready = 1'b0;
        repeat (5) step();
        src_ready = 1'b1;
        repeat (8) step();
        check("bp_n_starts", start_log.size(), 1);
        if (start_log.size() > 0) check("bp_start_cycle", start_cyc[0] - t0, 5);

        // Asynchronous reset while a norm load is in BUSY.
        apply_reset();
        done_lat = 0; ld_req = 3'b100;
        repeat (4) step();
        check("rst_busy_before", busy_o, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_outputs",
                 {busy_o, src_start_o, snk_start_o, ld_done_o, st_done_o, ld_st_sel_o, ld_which_sel_o, err_o}, 0);
        step();
        rst_n = 1'b1;
        check("rst_no_done", ld_done_cyc, -1);
        start_log.delete();
        done_lat = 2; ld_req = 3'b111;
        repeat (6) step();
        if (start_log.size() > 0) check("rst_restart_feat", start_log[0], 0);
        else check("rst_restart_started", 0, 1);

        // Stalled transfer: watchdog fires, or the transfer waits indefinitely.
        apply_reset();
        done_lat = 0; t0 = cyc + 1; ld_req = 3'b001;
        repeat (30) step();
`ifdef RBE_STREAMER_SCHED_WATCHDOG_EN
        check("wd_err_cycle", err_rise_cyc - t0, 17);
        check("wd_done_cycle", ld_done_cyc - t0, 17);
        check("wd_err_held", err_o, 1);
`else
        check("stall_still_busy", busy_o, 1);
        check("stall_err_zero", err_o, 0);
`endif
        clear = 1'b1;
        step();
        clear = 1'b0; ld_req = 3'b000;
        check("clear_idle", busy_o, 0);
        check("clear_err", err_o, 0);
        step();

        // Randomized traffic including enable holds, clears and stray done pulses.
        apply_reset();
        done_lat = 1; rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0; enable = 1'b1; clear = 1'b0;
        check("rand_activity", start_log.size() > 100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
